// File: rtl/shift_right_seq_pkg.sv
// ============================================================================
// shift_right_seq_pkg : shared encodings and default sizes for the shifter family
// Revision: 1.0
// ============================================================================
`default_nettype none

package shift_right_seq_pkg;

  localparam int SRS_WIDTH = 32;
  localparam int SRS_SHW   = 4;

  localparam logic [1:0] SHR_LOG = 2'b00;
  localparam logic [1:0] SHR_ARI = 2'b01;
  localparam logic [1:0] SHR_ROT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } srs_state_t;

endpackage

`default_nettype wire

// File: rtl/shift_right_seq_if.sv
// ============================================================================
// shift_right_seq_if : request/result bundle; carry_out exists only with SHIFT_RIGHT_CARRY_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

interface shift_right_seq_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 4
);
  logic             start;
  logic [WIDTH-1:0] sr1;
  logic [SHW-1:0]   shift;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef SHIFT_RIGHT_CARRY_EN
  logic             carry_out;
`endif

  modport master (
    output start, sr1, shift, mode,
    input  busy, done, result
`ifdef SHIFT_RIGHT_CARRY_EN
    , input carry_out
`endif
  );

  modport slave (
    input  start, sr1, shift, mode,
    output busy, done, result
`ifdef SHIFT_RIGHT_CARRY_EN
    , output carry_out
`endif
  );
endinterface

`default_nettype wire

// File: rtl/shift_right_seq_shr_step.sv
// ============================================================================
// shr_step : combinational one-bit right step with mode-selected fill bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module shr_step
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH = SRS_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o,
  output logic             bit_o
);

  logic fill;

  always_comb begin
    fill = 1'b0;
    case (mode_i)
      SHR_ARI: fill = data_i[WIDTH-1];
      SHR_ROT: fill = data_i[0];
      default: fill = 1'b0;  // reserved encoding behaves as logical
    endcase
  end

  assign data_o = {fill, data_i[WIDTH-1:1]};
  assign bit_o  = data_i[0];

endmodule

`default_nettype wire

// File: rtl/shift_right_seq.sv
// ============================================================================
// shift_right_seq : multi-cycle right shifter/rotator, one bit per clock.
// Optional carry_out output enabled by SHIFT_RIGHT_CARRY_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module shift_right_seq
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH = SRS_WIDTH,
  parameter int SHW   = SRS_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_right_seq_if.slave bus
);

  srs_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;

  logic [WIDTH-1:0] step_data;
  logic             step_bit;
  logic             accept;

  shr_step #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .mode_i (mode_q),
    .data_o (step_data),
    .bit_o  (step_bit)
  );

  // A new request is taken in IDLE and also in DONE, giving back-to-back issue.
  assign accept = bus.start && (state_q != ST_SHIFT);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      ST_SHIFT: begin
        data_d = step_data;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (accept) begin
      data_d  = bus.sr1;
      cnt_d   = bus.shift;
      mode_d  = bus.mode;
      state_d = (bus.shift == '0) ? ST_DONE : ST_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= SHR_LOG;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.busy   = (state_q == ST_SHIFT);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = data_q;

`ifdef SHIFT_RIGHT_CARRY_EN
  logic carry_q, carry_d;

  always_comb begin
    carry_d = carry_q;
    if (state_q == ST_SHIFT) carry_d = step_bit;
    if (accept && (bus.shift == '0)) carry_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  assign bus.carry_out = carry_q;
`else
  logic step_bit_unused;
  assign step_bit_unused = step_bit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_right_seq.sv
// ============================================================================
// tb_shift_right_seq : self-checking bench, directed plan plus randomized model check
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_right_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  shift_right_seq_if #(.WIDTH(32), .SHW(4)) bus ();

  shift_right_seq #(.WIDTH(32), .SHW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [31:0] a, input int n, input logic [1:0] m);
    logic [31:0] r;
    case (m)
      2'b01:   r = 32'($signed(a) >>> n);
      2'b10:   r = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      default: r = a >> n;
    endcase
    return r;
  endfunction

  function automatic logic ref_carry(input logic [31:0] a, input int n);
    return (n == 0) ? 1'b0 : a[n-1];
  endfunction

  task automatic do_op(input string name, input logic [31:0] a, input int n,
                       input logic [1:0] m, input logic [31:0] exp_res, input logic exp_c);
    int cycles;
    int busy_cycles;
    logic [31:0] held;
    @(negedge clk);
    bus.start = 1'b1; bus.sr1 = a; bus.shift = 4'(n); bus.mode = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.sr1 = $urandom; bus.shift = 4'($urandom); bus.mode = 2'($urandom);
    cycles = 1; busy_cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      if (bus.busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      cycles++;
    end
    n_checks++;
    if (cycles !== n + 1) begin
      n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, cycles, n + 1);
    end
    n_checks++;
    if (busy_cycles !== n) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, n);
    end
    n_checks++;
    if (bus.result !== exp_res) begin
      n_fail++; $display("FAIL %s result: got %h expected %h", name, bus.result, exp_res);
    end
`ifdef SHIFT_RIGHT_CARRY_EN
    n_checks++;
    if (bus.carry_out !== exp_c) begin
      n_fail++; $display("FAIL %s carry_out: got %b expected %b", name, bus.carry_out, exp_c);
    end
`else
    if (exp_c === 1'bx) $display("note: unknown carry expectation in %s", name);
`endif
    held = bus.result;
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== held) begin
      n_fail++;
      $display("FAIL %s hold: got done=%b busy=%b result=%h expected done=0 busy=0 result=%h",
               name, bus.done, bus.busy, bus.result, held);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.sr1 = '0; bus.shift = '0; bus.mode = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h expected 0 0 00000000",
               bus.busy, bus.done, bus.result);
    end
`ifdef SHIFT_RIGHT_CARRY_EN
    n_checks++;
    if (bus.carry_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_carry: got %b expected 0", bus.carry_out);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_op("logical",  32'h80000001, 4,  2'b00, 32'h08000000, 1'b0);
    do_op("arith_neg", 32'hF0000000, 15, 2'b01, 32'hFFFFE000, 1'b0);
    do_op("arith_pos", 32'h70000000, 15, 2'b01, 32'h0000E000, 1'b0);
    do_op("rotate",   32'h0000000F, 4,  2'b10, 32'hF0000000, 1'b1);
    do_op("reserved", 32'h0000000F, 4,  2'b11, 32'h00000000, 1'b1);
    do_op("zero_shift", 32'h12345678, 0, 2'b00, 32'h12345678, 1'b0);
    do_op("carry_4",  32'h00000008, 4,  2'b00, 32'h00000000, 1'b1);
    do_op("carry_3",  32'h00000008, 3,  2'b00, 32'h00000001, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cycles;
    @(negedge clk);
    bus.start = 1'b1; bus.sr1 = 32'h12345678; bus.shift = 4'd0; bus.mode = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b1 || bus.result !== 32'h12345678) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b result=%h expected done=1 result=12345678",
               bus.done, bus.result);
    end
    bus.sr1 = 32'h00000100; bus.shift = 4'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done);
    end
    cycles = 1;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_checks++;
    if (cycles !== 9 || bus.result !== 32'h00000001) begin
      n_fail++;
      $display("FAIL b2b_second: got latency=%0d result=%h expected latency=9 result=00000001",
               cycles, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int cycles;
    @(negedge clk);
    bus.start = 1'b1; bus.sr1 = 32'h80000001; bus.shift = 4'd6; bus.mode = 2'b00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.sr1 = 32'hDEADBEEF; bus.shift = 4'd1; bus.mode = 2'b10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cycles = 3;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_checks++;
    if (cycles !== 7 || bus.result !== 32'h02000000) begin
      n_fail++;
      $display("FAIL busy_ignore: got latency=%0d result=%h expected latency=7 result=02000000",
               cycles, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.sr1 = 32'hA5A5A5A5; bus.shift = 4'd10; bus.mode = 2'b01;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b result=%h expected 0 0 00000000",
               bus.busy, bus.done, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++; $display("FAIL reset_abort: got %0d active cycles expected 0", seen_done);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int n;
    logic [1:0] m;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      n = int'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      do_op($sformatf("random%0d", i), a, n, m, ref_result(a, n, m), ref_carry(a, n));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Multi-cycle right shifter/rotator, the right-direction counterpart of the CPU's combinational left shift/rotate unit.
- Shifts a 32-bit operand right by 0..15 using one bit per clock.
- Supports logical, arithmetic and rotate modes.
- Sits beside the ALU in the execute stage; the pipeline stalls on busy and picks up result on done.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 4, width of the shift-amount port; maximum shift is 2^SHW-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- sr1  input  WIDTH  operand to shift, captured on accepted start.
- shift  input  SHW  shift amount, captured on accepted start.
- mode  input  2  00 logical right, 01 arithmetic right, 10 rotate right, 11 reserved (treated as 00).
- busy  output  1  high while shifting; start ignored.
- done  output  1  one-cycle pulse: result valid.
- result  output  WIDTH  shifted value; held stable from done until next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, result=0, internal counter=0.
  - Reset asserted mid-operation aborts with no done pulse.
- FSM states: IDLE, SHIFT, DONE. busy=(state==SHIFT); done=(state==DONE); both registered.
- Accept:
  - start=1 while state is IDLE or DONE loads data<=sr1, cnt<=shift, mode_r<=mode.
  - Next state is DONE if shift==0, else SHIFT.
- SHIFT, each cycle:
  - data shifts right by one.
  - Fill bit: 0 for logical, data[WIDTH-1] for arithmetic, data[0] for rotate.
  - cnt<=cnt-1; when cnt==1, next state is DONE.
- DONE:
  - Lasts exactly one cycle.
  - Next state is IDLE, or a new SHIFT/DONE if start=1 (back-to-back accepted, no bubble).
- Latency: done asserts exactly N+1 clock edges after the accepting edge, N = captured shift (N=0 gives 1 cycle; N=15 gives 16 cycles).
- result is driven directly from the data register:
  - Intermediate values are visible during SHIFT but are not valid.
  - Only the value at done, and afterwards, is architecturally defined.
- start while busy=1: ignored, with no effect on the operation in flight. sr1/shift/mode changes while busy: ignored.
- Arithmetic/rotate boundaries:
  - Arithmetic of a negative operand by 15 gives all ones in the upper 16 bits.
  - Rotate by N equals the logical right shift by N ORed with sr1 shifted left by (WIDTH-N).
- Counter width SHW; no wrap is possible because loading only occurs in IDLE/DONE.

Optional Feature:
- Macro: SHIFT_RIGHT_CARRY_EN.
- When defined:
  - Adds output carry_out (1 bit, reset 0).
  - carry_out registers the last bit shifted out of data[0] each SHIFT cycle.
  - It is cleared to 0 on an accepted start with shift==0.
  - It is valid with done and held until the next accept.
- When undefined: the port and register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Mode encodings: SHR_LOG=2'b00, SHR_ARI=2'b01, SHR_ROT=2'b10.
  - FSM state encodings: IDLE/SHIFT/DONE.
  - Default WIDTH/SHW constants, reused by the left shifter and ALU decode.
- One natural sub-module, shr_step:
  - Combinational one-bit right step, inputs data and mode, outputs next data and the shifted-out bit.
  - Instantiated once inside the FSM datapath.

Test Plan:
- Logical: sr1=0x80000001, shift=4, mode=00 -> busy high 4 cycles, done on 5th edge, result=0x08000000.
- Arithmetic: sr1=0xF0000000, shift=15, mode=01 -> done after 16 edges, result=0xFFFFE000. Repeat with sr1=0x70000000 -> 0x0000E000.
- Rotate: sr1=0x0000000F, shift=4, mode=10 -> result=0xF0000000. Reserved mode=11, same operand -> 0x00000000.
- Zero shift and back-to-back:
  - sr1=0x12345678, shift=0 -> done 1 cycle after start, result=0x12345678.
  - start held during that done with sr1=0x00000100, shift=8 -> accepted with no idle cycle, result=0x00000001.
- Busy/reset:
  - start pulsed while busy with different sr1 -> ignored, original result delivered.
  - rst_n low during SHIFT -> busy=0, done=0, result=0 immediately, no done pulse.
- With SHIFT_RIGHT_CARRY_EN: sr1=0x00000008, shift=4, mode=00 -> result=0, carry_out=1. Shift=3 -> result=1, carry_out=0.
